// File: rtl/modulo_serial_arb.sv
// Bit-serial two's-complement modulus/negate engine shared by two requesters.
// Define MODULO_SERIAL_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
`timescale 1ns/1ps

module modulo_serial_arb #(
  parameter int WIDTH = 6
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             REQ0,
  input  logic [WIDTH-1:0] A0,
  input  logic             OP0,
  input  logic             REQ1,
  input  logic [WIDTH-1:0] A1,
  input  logic             OP1,
  output logic             GNT0,
  output logic             GNT1,
  output logic             BUSY,
  output logic             OWNER,
  output logic [WIDTH-1:0] S,
  output logic             OVF,
  output logic             DONE
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-2:0] res;      // upper WIDTH-1 result bits; the next sum completes the word
  logic             carry;
  logic             sign;
  logic             tag;
  logic             ovf_pend;
`ifndef MODULO_SERIAL_FIXED_PRIO_EN
  logic             last;
`endif

  logic             any_req;
  logic             winner;
  logic [WIDTH-1:0] win_a;
  logic             win_op;
  logic             win_sign;
  logic             aux;
  logic             sum;
  logic [WIDTH-1:0] next_res;

  // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    any_req = REQ0 | REQ1;
`ifdef MODULO_SERIAL_FIXED_PRIO_EN
    winner = ~REQ0;
`else
    if (REQ0 && REQ1) winner = ~last;
    else              winner = ~REQ0;
`endif
    win_a    = winner ? A1 : A0;
    win_op   = winner ? OP1 : OP0;
    win_sign = win_op | win_a[WIDTH-1];
    aux      = shreg[0] ^ sign;
    sum      = aux ^ carry;
    next_res = {sum, res};
  end

  assign BUSY = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      cnt      <= '0;
      shreg    <= '0;
      res      <= '0;
      carry    <= 1'b0;
      sign     <= 1'b0;
      tag      <= 1'b0;
      ovf_pend <= 1'b0;
`ifndef MODULO_SERIAL_FIXED_PRIO_EN
      last     <= 1'b1;
`endif
      S        <= '0;
      OVF      <= 1'b0;
      OWNER    <= 1'b0;
      DONE     <= 1'b0;
      GNT0     <= 1'b0;
      GNT1     <= 1'b0;
    end else begin
      GNT0 <= 1'b0;
      GNT1 <= 1'b0;
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            shreg    <= win_a;
            sign     <= win_sign;
            carry    <= win_sign;
            ovf_pend <= win_sign && (win_a == MOST_NEG);
            tag      <= winner;
`ifndef MODULO_SERIAL_FIXED_PRIO_EN
            last     <= winner;
`endif
            GNT0     <= ~winner;
            GNT1     <= winner;
            cnt      <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          shreg <= shreg >> 1;
          carry <= aux & carry;
          res   <= next_res[WIDTH-1:1];
          if (cnt == CW'(WIDTH - 1)) begin
            state <= FIN;
            S     <= next_res;
            OWNER <= tag;
            OVF   <= ovf_pend;
            DONE  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modulo_serial_arb.sv
// Self-checking bench for modulo_serial_arb: directed cases plus randomized operations against an arithmetic model.
`timescale 1ns/1ps

module tb_modulo_serial_arb;

  localparam int W = 6;

  logic         CLK = 1'b0;
  logic         RESET_N = 1'b0;
  logic         REQ0 = 1'b0, OP0 = 1'b0, REQ1 = 1'b0, OP1 = 1'b0;
  logic [W-1:0] A0 = '0, A1 = '0;
  logic         GNT0, GNT1, BUSY, OWNER, OVF, DONE;
  logic [W-1:0] S;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic tb_last = 1'b1;

  modulo_serial_arb #(.WIDTH(W)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .REQ0(REQ0), .A0(A0), .OP0(OP0),
    .REQ1(REQ1), .A1(A1), .OP1(OP1),
    .GNT0(GNT0), .GNT1(GNT1), .BUSY(BUSY), .OWNER(OWNER),
    .S(S), .OVF(OVF), .DONE(DONE)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Reference: |A| or -A in plain integer arithmetic; overflow when the magnitude is 2^(W-1).
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic op);
    int v, r;
    v = $signed(a);
    r = (op || v < 0) ? -v : v;
    model = {(r == (1 << (W - 1))), W'(r)};
  endfunction

  function automatic logic exp_winner_both();
`ifdef MODULO_SERIAL_FIXED_PRIO_EN
    exp_winner_both = 1'b0;
`else
    exp_winner_both = ~tb_last;
`endif
  endfunction

  task automatic issue(input logic r, input logic [W-1:0] a, input logic op,
                       output logic got, output logic busy_g, output int lat,
                       output logic [W-1:0] s, output logic ovf, output logic own);
    got = 0; busy_g = 0; lat = 0; s = '0; ovf = 0; own = 0;
    @(negedge CLK);
    if (r) begin REQ1 = 1; A1 = a; OP1 = op; end
    else   begin REQ0 = 1; A0 = a; OP0 = op; end
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if ((r ? GNT1 : GNT0) === 1'b1) begin got = 1; busy_g = BUSY; break; end
    end
    REQ0 = 0; REQ1 = 0;
    if (got) begin
      tb_last = r;
      for (int i = 1; i <= 30; i++) begin
        @(negedge CLK);
        if (DONE === 1'b1) begin lat = i; s = S; ovf = OVF; own = OWNER; break; end
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge CLK);
    n_checks++;
    if ({GNT0, GNT1, BUSY, OWNER, S, OVF, DONE} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %b want all zero", {GNT0, GNT1, BUSY, OWNER, S, OVF, DONE});
    end
    RESET_N = 1'b1;
    @(negedge CLK);
    n_checks++;
    if ({GNT0, GNT1, BUSY, DONE} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_idle: got %b want 0000", {GNT0, GNT1, BUSY, DONE});
    end
  endtask

  task automatic test_single();
    logic got, busy_g, ovf, own; int lat; logic [W-1:0] s; bit extra;
    issue(1'b0, 6'b111011, 1'b0, got, busy_g, lat, s, ovf, own);
    n_checks++; if (got !== 1'b1)   begin n_fail++; $display("FAIL single_gnt0: got %b want 1", got); end
    n_checks++; if (busy_g !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", busy_g); end
    n_checks++; if (lat != W)       begin n_fail++; $display("FAIL single_latency: got %0d want %0d", lat, W); end
    n_checks++;
    if ({s, own, ovf} !== {6'b000101, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL single_result: got S=%b OWNER=%b OVF=%b want S=000101 OWNER=0 OVF=0", s, own, ovf);
    end
    @(negedge CLK);
    n_checks++; if (DONE !== 1'b0) begin n_fail++; $display("FAIL single_done_pulse: got %b want 0", DONE); end
    extra = 0;
    repeat (12) begin @(negedge CLK); if (GNT0 === 1'b1 || DONE === 1'b1) extra = 1; end
    n_checks++; if (extra) begin n_fail++; $display("FAIL single_no_second_op: got activity want none"); end
    n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL single_idle_busy: got %b want 0", BUSY); end
  endtask

  task automatic test_req1_negate();
    logic got, busy_g, ovf, own; int lat; logic [W-1:0] s;
    issue(1'b1, 6'b001010, 1'b1, got, busy_g, lat, s, ovf, own);
    n_checks++;
    if (!got || {s, own, ovf} !== {6'b110110, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL neg10: got gnt=%b S=%b OWNER=%b OVF=%b want gnt=1 S=110110 OWNER=1 OVF=0", got, s, own, ovf);
    end
    issue(1'b1, 6'b000000, 1'b1, got, busy_g, lat, s, ovf, own);
    n_checks++;
    if (!got || {s, own, ovf} !== {6'b000000, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL neg0: got gnt=%b S=%b OWNER=%b OVF=%b want gnt=1 S=000000 OWNER=1 OVF=0", got, s, own, ovf);
    end
  endtask

  task automatic test_overflow();
    logic got, busy_g, ovf, own; int lat; logic [W-1:0] s;
    for (int op = 0; op < 2; op++) begin
      issue(1'b0, 6'b100000, op[0], got, busy_g, lat, s, ovf, own);
      n_checks++;
      if (!got || {s, ovf} !== {6'b100000, 1'b1}) begin
        n_fail++; $display("FAIL ovf_op%0d: got gnt=%b S=%b OVF=%b want gnt=1 S=100000 OVF=1", op, got, s, ovf);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic got, w, exp_w; int prev_done; logic [W:0] exp;
    A0 = W'($urandom); A1 = W'($urandom); OP0 = 1'($urandom); OP1 = 1'($urandom);
    @(negedge CLK);
    REQ0 = 1; REQ1 = 1;
    prev_done = -1;
    for (int k = 0; k < 6; k++) begin
      exp_w = exp_winner_both();
      got = 0; w = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge CLK);
        if (GNT0 === 1'b1 || GNT1 === 1'b1) begin got = 1; w = GNT1; break; end
      end
      n_checks++;
      if (!got || w !== exp_w || (GNT0 & GNT1)) begin
        n_fail++; $display("FAIL b2b_grant%0d: got gnt=%b idx=%b want idx=%b", k, got, w, exp_w);
      end
      tb_last = exp_w;
      got = 0;
      for (int i = 0; i < 30; i++) begin
        @(negedge CLK);
        if (DONE === 1'b1) begin got = 1; break; end
      end
      exp = exp_w ? model(A1, OP1) : model(A0, OP0);
      n_checks++;
      if (!got || OWNER !== exp_w || {OVF, S} !== exp) begin
        n_fail++; $display("FAIL b2b_result%0d: got done=%b OWNER=%b OVF,S=%b want OWNER=%b OVF,S=%b", k, got, OWNER, {OVF, S}, exp_w, exp);
      end
      if (prev_done >= 0) begin
        n_checks++;
        if (cyc - prev_done != W + 2) begin
          n_fail++; $display("FAIL b2b_spacing%0d: got %0d want %0d", k, cyc - prev_done, W + 2);
        end
      end
      prev_done = cyc;
    end
    REQ0 = 0; REQ1 = 0;
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_capture();
    logic got; logic [W-1:0] a; logic op; logic [W:0] exp;
    a = W'($urandom) | 6'b100001; op = 1'($urandom);
    exp = model(a, op);
    @(negedge CLK);
    REQ0 = 1; A0 = a; OP0 = op;
    got = 0;
    for (int i = 0; i < 20; i++) begin @(negedge CLK); if (GNT0 === 1'b1) begin got = 1; break; end end
    REQ0 = 0; A0 = ~a; OP0 = ~op;
    repeat (2) @(negedge CLK);
    A0 = W'($urandom); OP0 = ~OP0;
    for (int i = 0; i < 30 && got; i++) begin
      if (DONE === 1'b1) break;
      @(negedge CLK);
    end
    n_checks++;
    if (DONE !== 1'b1 || {OVF, S} !== exp) begin
      n_fail++; $display("FAIL capture: got done=%b OVF,S=%b want done=1 OVF,S=%b", DONE, {OVF, S}, exp);
    end
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_reset_mid();
    logic got; bit saw_done; logic [W:0] exp; logic [W-1:0] a;
    @(negedge CLK);
    REQ0 = 1; A0 = 6'b111111; OP0 = 0;
    got = 0;
    for (int i = 0; i < 20; i++) begin @(negedge CLK); if (GNT0 === 1'b1) begin got = 1; break; end end
    REQ0 = 0;
    repeat (3) @(negedge CLK);
    RESET_N = 1'b0;
    #1;
    n_checks++;
    if (!got || {GNT0, GNT1, BUSY, OWNER, S, OVF, DONE} !== '0) begin
      n_fail++; $display("FAIL reset_mid_outputs: got gnt=%b outs=%b want all zero", got, {GNT0, GNT1, BUSY, OWNER, S, OVF, DONE});
    end
    saw_done = 0;
    repeat (3) begin @(negedge CLK); if (DONE === 1'b1) saw_done = 1; end
    RESET_N = 1'b1;
    tb_last = 1'b1;
    repeat (2) begin @(negedge CLK); if (DONE === 1'b1) saw_done = 1; end
    n_checks++; if (saw_done) begin n_fail++; $display("FAIL reset_mid_no_done: got DONE want none"); end
    a = W'($urandom);
    A0 = a; OP0 = 1'($urandom); A1 = ~a; OP1 = 1'($urandom);
    exp = model(a, OP0);
    REQ1 = 1; REQ0 = 1;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (GNT0 === 1'b1 || GNT1 === 1'b1) begin got = 1; break; end
    end
    n_checks++;
    if (!got || GNT0 !== 1'b1 || GNT1 !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_first_grant: got GNT0=%b GNT1=%b want GNT0=1 GNT1=0", GNT0, GNT1);
    end
    REQ0 = 0; REQ1 = 0;
    tb_last = 1'b0;
    got = 0;
    for (int i = 0; i < 30; i++) begin @(negedge CLK); if (DONE === 1'b1) begin got = 1; break; end end
    n_checks++;
    if (!got || OWNER !== 1'b0 || {OVF, S} !== exp) begin
      n_fail++; $display("FAIL reset_mid_result: got done=%b OWNER=%b OVF,S=%b want OWNER=0 OVF,S=%b", got, OWNER, {OVF, S}, exp);
    end
  endtask

  task automatic test_random();
    logic got, busy_g, ovf, own, r, op; int lat; logic [W-1:0] s, a; logic [W:0] exp;
    for (int k = 0; k < 16; k++) begin
      r = 1'($urandom); op = 1'($urandom);
      case ($urandom_range(0, 5))
        0:       a = 6'b100000;
        1:       a = 6'b011111;
        2:       a = 6'b111111;
        default: a = W'($urandom);
      endcase
      exp = model(a, op);
      issue(r, a, op, got, busy_g, lat, s, ovf, own);
      n_checks++;
      if (!got || lat != W || own !== r || {ovf, s} !== exp) begin
        n_fail++; $display("FAIL random%0d: A=%b OP=%b got gnt=%b lat=%0d OWNER=%b OVF,S=%b want lat=%0d OWNER=%b OVF,S=%b",
                           k, a, op, got, lat, own, {ovf, s}, W, r, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_req1_negate();
    test_overflow();
    test_back_to_back();
    test_capture();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
